// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined Booth radix-4 multiplier / MAC.
package mul_pkg;

    // Operation encodings; 2'b11 behaves as MUL.
    localparam logic [1:0] MUL_OP_MUL  = 2'b00;
    localparam logic [1:0] MUL_OP_MADD = 2'b01;
    localparam logic [1:0] MUL_OP_MSUB = 2'b10;

    // Booth digit select. Bit 2 is the "negative" flag, bits 1:0 the magnitude.
    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'b000,
        BOOTH_POS1 = 3'b001,
        BOOTH_POS2 = 3'b010,
        BOOTH_NEG1 = 3'b101,
        BOOTH_NEG2 = 3'b110
    } booth_sel_t;

    // Radix-4 recoding of the multiplier triplet {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_sel_t booth_encode(input logic [2:0] trip);
        booth_sel_t sel;
        case (trip)
            3'b001, 3'b010: sel = BOOTH_POS1;
            3'b011:         sel = BOOTH_POS2;
            3'b100:         sel = BOOTH_NEG2;
            3'b101, 3'b110: sel = BOOTH_NEG1;
            default:        sel = BOOTH_ZERO;
        endcase
        return sel;
    endfunction

    // Negating every digit negates the whole product (used for MSUB).
    function automatic booth_sel_t booth_negate(input booth_sel_t sel);
        booth_sel_t res;
        case (sel)
            BOOTH_POS1: res = BOOTH_NEG1;
            BOOTH_POS2: res = BOOTH_NEG2;
            BOOTH_NEG1: res = BOOTH_POS1;
            BOOTH_NEG2: res = BOOTH_POS2;
            default:    res = BOOTH_ZERO;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mul_booth_tree.sv
// Combinational Booth radix-4 partial-product generation and carry-save
// reduction of all rows (partial products, negation corrections and the
// accumulator) down to a sum/carry pair whose sum is acc +/- a*b mod 2^(2W).
module mul_booth_tree
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               sign_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [2*WIDTH-1:0] sum_o,
    output logic [2*WIDTH-1:0] carry_o
);

    localparam int P     = 2 * WIDTH;
    localparam int XW    = WIDTH + 2;
    localparam int NPP   = WIDTH / 2 + 1;
    localparam int NROWS = NPP + 2;
    localparam int NPAD  = NROWS + 2;

    logic [XW-1:0] a_ext;
    logic [XW:0]   b_pad;
    logic [P-1:0]  a_wide;
    logic [P-1:0]  rows [NROWS];
    logic [P-1:0]  corr;
    logic [P-1:0]  mag;
    booth_sel_t    sel;
    logic          neg_prod;

    logic [P-1:0]  work [NPAD];
    logic [P-1:0]  nxt  [NPAD];
    int            cnt_rows;
    int            m;

    // Operands widened to WIDTH+2 bits; the extra LSB zero of b_pad is b[-1].
    assign a_ext  = {{2{sign_i & a_i[WIDTH-1]}}, a_i};
    assign b_pad  = {{2{sign_i & b_i[WIDTH-1]}}, b_i, 1'b0};
    assign a_wide = {{(P-XW){a_ext[XW-1]}}, a_ext};

    // Build partial-product rows; negative digits are ~mag with a +1 in the correction row.
    always_comb begin
        corr     = '0;
        mag      = '0;
        sel      = BOOTH_ZERO;
        neg_prod = (op_i == MUL_OP_MSUB);
        for (int i = 0; i < NPP; i++) begin
            sel = booth_encode(b_pad[2*i +: 3]);
            if (neg_prod) begin
                sel = booth_negate(sel);
            end
            case (sel)
                BOOTH_POS1, BOOTH_NEG1: mag = a_wide;
                BOOTH_POS2, BOOTH_NEG2: mag = a_wide << 1;
                default:                mag = '0;
            endcase
            if (sel == BOOTH_NEG1 || sel == BOOTH_NEG2) begin
                rows[i]   = (~mag) << (2 * i);
                corr[2*i] = 1'b1;
            end else begin
                rows[i] = mag << (2 * i);
            end
        end
        rows[NPP]     = corr;
        rows[NPP + 1] = (op_i == MUL_OP_MADD || op_i == MUL_OP_MSUB) ? acc_i : '0;
    end

    // Wallace-style levels of 3:2 compressors until only two rows remain.
    always_comb begin
        work     = '{default: '0};
        nxt      = '{default: '0};
        cnt_rows = NROWS;
        m        = 0;
        for (int r = 0; r < NROWS; r++) begin
            work[r] = rows[r];
        end
        for (int lv = 0; lv < NROWS; lv++) begin
            if (cnt_rows > 2) begin
                nxt = '{default: '0};
                m   = 0;
                for (int g = 0; g < NROWS; g += 3) begin
                    if (g + 2 < cnt_rows) begin
                        nxt[m]     = work[g] ^ work[g+1] ^ work[g+2];
                        nxt[m + 1] = ((work[g] & work[g+1]) | (work[g] & work[g+2])
                                     | (work[g+1] & work[g+2])) << 1;
                        m = m + 2;
                    end else begin
                        for (int k = 0; k < 2; k++) begin
                            if (g + k < cnt_rows) begin
                                nxt[m] = work[g+k];
                                m = m + 1;
                            end
                        end
                    end
                end
                work     = nxt;
                cnt_rows = m;
            end
        end
        sum_o   = work[0];
        carry_o = work[1];
    end

endmodule

// File: rtl/mul_pipe.sv
// Fully pipelined Booth radix-4 multiply / multiply-accumulate unit.
// Stage 1 holds the compressed sum/carry pair, stage 2 the carry-propagated
// result, further stages are plain delay registers. Handshake:
//   an op transfers in on a clock edge where in_valid & in_ready, a result
//   transfers out where out_valid & out_ready; a stalled output (out_valid &
//   ~out_ready) freezes every stage, and in_ready never depends on in_valid.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2*WIDTH-1:0] in_acc,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int P = 2 * WIDTH;

    logic             stall;
    logic             accept;
    logic [P-1:0]     tree_sum;
    logic [P-1:0]     tree_carry;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];
    logic [P-1:0]      res_q [STAGES];
    logic [P-1:0]      res_d [STAGES];
    logic [P-1:0]      car_q, car_d;

    mul_booth_tree #(.WIDTH(WIDTH)) u_tree (
        .sign_i  (in_sign),
        .op_i    (in_op),
        .a_i     (in_a),
        .b_i     (in_b),
        .acc_i   (in_acc),
        .sum_o   (tree_sum),
        .carry_o (tree_carry)
    );

    assign stall    = vld_q[STAGES-1] & ~out_ready;
    assign in_ready = ~stall & ~flush;
    assign accept   = in_valid & in_ready;

    assign out_valid  = vld_q[STAGES-1];
    assign out_result = res_q[STAGES-1];
    assign out_tag    = tag_q[STAGES-1];

    // Next state: flush kills valid/tag, otherwise advance unless stalled.
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        res_d = res_q;
        car_d = car_q;
        if (flush) begin
            vld_d = '0;
            for (int s = 0; s < STAGES; s++) begin
                tag_d[s] = '0;
            end
        end else if (!stall) begin
            vld_d[0] = accept;
            tag_d[0] = in_tag;
            if (STAGES == 1) begin
                res_d[0] = tree_sum + tree_carry;
            end else begin
                res_d[0] = tree_sum;
                car_d    = tree_carry;
            end
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s] = vld_q[s-1];
                tag_d[s] = tag_q[s-1];
                res_d[s] = (s == 1) ? (res_q[0] + car_q) : res_q[s-1];
            end
        end
    end

    // Stage registers; reset clears everything including the output data.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            car_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                tag_q[s] <= '0;
                res_q[s] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            res_q <= res_d;
            car_q <= car_d;
        end
    end

endmodule
